// File: rtl/alu_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_if
// Bundles every non-clock signal of the shared-ALU arbiter:
//   req0_* / req1_* : two requester valid/ready channels with operands,
//                     EXE_CMD and status-update flag
//   alu_*           : registered operands/command/status to the ALU, and
//                     the combinational ALU result/flags coming back
//   resp_*          : tagged valid/ready response channel
//   status_reg      : architectural NZCV register (V in bit 0)
// Modports: slave  = arbiter side, master = requesters/ALU/consumer side.
// ---------------------------------------------------------------------------
interface alu_share_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_val1;
    logic [DATA_W-1:0] req0_val2;
    logic [3:0]        req0_cmd;
    logic              req0_s;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_val1;
    logic [DATA_W-1:0] req1_val2;
    logic [3:0]        req1_cmd;
    logic              req1_s;

    logic [DATA_W-1:0] alu_val1;
    logic [DATA_W-1:0] alu_val2;
    logic [3:0]        alu_cmd;
    logic [3:0]        alu_status;
    logic [DATA_W-1:0] alu_res;
    logic [3:0]        alu_status_out;

    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [DATA_W-1:0] resp_res;
    logic [3:0]        resp_status;
    logic [3:0]        status_reg;

    modport slave (
        input  req0_valid, req0_val1, req0_val2, req0_cmd, req0_s,
        output req0_ready,
        input  req1_valid, req1_val1, req1_val2, req1_cmd, req1_s,
        output req1_ready,
        output alu_val1, alu_val2, alu_cmd, alu_status,
        input  alu_res, alu_status_out,
        output resp_valid, resp_id, resp_res, resp_status, status_reg,
        input  resp_ready
    );

    modport master (
        output req0_valid, req0_val1, req0_val2, req0_cmd, req0_s,
        input  req0_ready,
        output req1_valid, req1_val1, req1_val2, req1_cmd, req1_s,
        input  req1_ready,
        input  alu_val1, alu_val2, alu_cmd, alu_status,
        output alu_res, alu_status_out,
        input  resp_valid, resp_id, resp_res, resp_status, status_reg,
        output resp_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Arbitrates two requesters onto one shared 32-bit ALU, sequences each
// operation IDLE -> EXEC -> RESP, owns the NZCV status register and returns
// a registered, tagged result.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_share_arbiter_if.slave (requests, ALU drive, response)
// Configuration:
//   ALU_ARB_ROUND_ROBIN_EN defined   -> ties go to the requester not granted
//                                       last (last_grant resets to 1)
//   ALU_ARB_ROUND_ROBIN_EN undefined -> requester 0 always wins a tie
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;

    logic              grant_s;
    logic              tie_grant_s;
    logic              ready0_s;
    logic              ready1_s;
    logic              hs_s;

    logic [DATA_W-1:0] val1_r;
    logic [DATA_W-1:0] val2_r;
    logic [3:0]        cmd_r;
    logic              s_r;
    logic              id_r;

    logic              resp_id_r;
    logic [DATA_W-1:0] resp_res_r;
    logic [3:0]        resp_status_r;
    logic [3:0]        status_r;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic              last_grant_r;

    // Priority pointer: remembers the requester granted at the last handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
        end else if (hs_s) begin
            last_grant_r <= grant_s;
        end
    end

    assign tie_grant_s = ~last_grant_r;
`else
    assign tie_grant_s = 1'b0;
`endif

    // Arbitration, ready generation and next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        ready0_s    = 1'b0;
        ready1_s    = 1'b0;
        hs_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    grant_s = tie_grant_s;
                end else if (bus.req1_valid) begin
                    grant_s = 1'b1;
                end else begin
                    grant_s = 1'b0;
                end
                ready0_s = bus.req0_valid && !grant_s;
                ready1_s = bus.req1_valid && grant_s;
                hs_s     = ready0_s || ready1_s;
                if (hs_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture at the handshake; these registers drive the ALU directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val1_r <= {DATA_W{1'b0}};
            val2_r <= {DATA_W{1'b0}};
            cmd_r  <= 4'd0;
            s_r    <= 1'b0;
            id_r   <= 1'b0;
        end else if (hs_s) begin
            val1_r <= grant_s ? bus.req1_val1 : bus.req0_val1;
            val2_r <= grant_s ? bus.req1_val2 : bus.req0_val2;
            cmd_r  <= grant_s ? bus.req1_cmd  : bus.req0_cmd;
            s_r    <= grant_s ? bus.req1_s    : bus.req0_s;
            id_r   <= grant_s;
        end
    end

    // Result capture at the end of EXEC; status register follows only when s was set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_id_r     <= 1'b0;
            resp_res_r    <= {DATA_W{1'b0}};
            resp_status_r <= 4'd0;
            status_r      <= 4'd0;
        end else if (state_r == ST_EXEC) begin
            resp_id_r     <= id_r;
            resp_res_r    <= bus.alu_res;
            resp_status_r <= bus.alu_status_out;
            if (s_r) begin
                status_r <= bus.alu_status_out;
            end
        end
    end

    assign bus.req0_ready  = ready0_s;
    assign bus.req1_ready  = ready1_s;
    assign bus.alu_val1    = val1_r;
    assign bus.alu_val2    = val2_r;
    assign bus.alu_cmd     = cmd_r;
    // ADC/SBC consume the stored carry, so the ALU always sees the live register.
    assign bus.alu_status  = status_r;
    assign bus.resp_valid  = (state_r == ST_RESP);
    assign bus.resp_id     = resp_id_r;
    assign bus.resp_res    = resp_res_r;
    assign bus.resp_status = resp_status_r;
    assign bus.status_reg  = status_r;

endmodule
